// File: rtl/t07_fpu_issue_ctrl_if.sv
// Request, FPU-side and writeback signals of the FP issue controller.
// master = core/FPU environment, slave = issue controller.
interface t07_fpu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_rs3;
  logic [4:0]  req_rd;

  logic [4:0]  fpu_op;
  logic [31:0] fpu_valA;
  logic [31:0] fpu_valB;
  logic [31:0] fpu_valC;
  logic        fpu_busy;
  logic [31:0] fpu_result;
  logic        fpu_overflow;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_int;
  logic [31:0] wb_data;

  logic        active;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        timeout_err;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rs3, req_rd,
    output fpu_busy, fpu_result, fpu_overflow, fflags_clr,
    input  req_ready, fpu_op, fpu_valA, fpu_valB, fpu_valC,
    input  wb_valid, wb_rd, wb_int, wb_data, active, fflags, timeout_err
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rs3, req_rd,
    input  fpu_busy, fpu_result, fpu_overflow, fflags_clr,
    output req_ready, fpu_op, fpu_valA, fpu_valB, fpu_valC,
    output wb_valid, wb_rd, wb_int, wb_data, active, fflags, timeout_err
  );
endinterface

// File: rtl/t07_fpu_issue_ctrl.sv
// FP issue controller: one op in flight, FPU inputs held stable, sticky fcsr flags, bounded FDIV wait.
// Latency accept->wb: EXEC + DONE (FDIV adds WAIT cycles); req_ready low from accept until DONE retires.
module t07_fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [4:0]  IDLE_OP = 5'd31
) (
  input logic            clk,
  input logic            nrst,
  t07_fpu_issue_ctrl_if.slave bus
);

  localparam int          CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]  OP_FDIV   = 5'd7;
  localparam logic [4:0]  OP_MAX    = 5'd23;
  localparam int          FL_NV     = 4;
  localparam int          FL_DZ     = 3;
  localparam int          FL_OF     = 2;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_DONE} state_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } fpu_req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        is_int;
    logic [31:0] data;
  } wb_t;

  state_e      state_q, state_d;
  fpu_req_t    fpu_q, fpu_d;
  wb_t         wb_q, wb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        tmo_q, tmo_d;
  logic [4:0]  flag_set;
  logic        req_legal;

  assign req_legal = (bus.req_op <= OP_MAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) state_d = req_legal ? S_EXEC : S_DONE;
      S_EXEC: state_d = (fpu_q.op == OP_FDIV) ? S_WAIT : S_DONE;
      S_WAIT: if (!bus.fpu_busy || (cnt_q == CNT_LAST)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.active    = (state_q != S_IDLE);
    bus.wb_valid  = (state_q == S_DONE);
  end

  // FPU inputs only move at accept and on the DONE->IDLE edge; EXEC/WAIT keep them frozen.
  always_comb begin
    fpu_d    = fpu_q;
    wb_d     = wb_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    flag_set = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wb_d.rd     = bus.req_rd;
          wb_d.is_int = (bus.req_op >= 5'd14) && (bus.req_op <= 5'd20);
          if (req_legal) begin
            fpu_d.op = bus.req_op;
            fpu_d.a  = bus.req_rs1;
            fpu_d.b  = bus.req_rs2;
            fpu_d.c  = bus.req_rs3;
          end else begin
            wb_d.data       = '0;
            flag_set[FL_NV] = 1'b1;
          end
        end
      end
      S_EXEC: begin
        cnt_d = '0;
        if (fpu_q.op != OP_FDIV) begin
          wb_d.data       = bus.fpu_result;
          flag_set[FL_OF] = ((fpu_q.op == 5'd21) || (fpu_q.op == 5'd22)) && bus.fpu_overflow;
        end
      end
      S_WAIT: begin
        // Only FDIV reaches WAIT, so the divide-by-zero check needs no opcode test.
        if (!bus.fpu_busy) begin
          wb_d.data       = bus.fpu_result;
          flag_set[FL_DZ] = (fpu_q.b == 32'd0);
        end else if (cnt_q == CNT_LAST) begin
          wb_d.data       = '0;
          flag_set[FL_NV] = 1'b1;
          flag_set[FL_DZ] = (fpu_q.b == 32'd0);
          tmo_d           = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        fpu_d.op = IDLE_OP;
        cnt_d    = '0;
      end
      default: ;
    endcase
    // A set on the same edge as a clear survives; older bits do not.
    fflags_d = (bus.fflags_clr ? 5'd0 : fflags_q) | flag_set;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fpu_q    <= '{op: IDLE_OP, a: 32'd0, b: 32'd0, c: 32'd0};
      wb_q     <= '0;
      cnt_q    <= '0;
      fflags_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      fpu_q    <= fpu_d;
      wb_q     <= wb_d;
      cnt_q    <= cnt_d;
      fflags_q <= fflags_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.fpu_op      = fpu_q.op;
  assign bus.fpu_valA    = fpu_q.a;
  assign bus.fpu_valB    = fpu_q.b;
  assign bus.fpu_valC    = fpu_q.c;
  assign bus.wb_rd       = wb_q.rd;
  assign bus.wb_int      = wb_q.is_int;
  assign bus.wb_data     = wb_q.data;
  assign bus.fflags      = fflags_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_t07_fpu_issue_ctrl.sv
// Directed bench for t07_fpu_issue_ctrl: default-TIMEOUT instance plus a TIMEOUT=8 instance.
module tb_t07_fpu_issue_ctrl;
  logic        clk;
  logic        nrst;
  int          n_vec;
  int          n_bad;
  int          pulses;
  logic [31:0] seen;

  t07_fpu_issue_ctrl_if bus ();
  t07_fpu_issue_ctrl_if bus_to ();

  t07_fpu_issue_ctrl dut (.clk(clk), .nrst(nrst), .bus(bus));
  t07_fpu_issue_ctrl #(.TIMEOUT(8)) dut_to (.clk(clk), .nrst(nrst), .bus(bus_to));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in FPU datapath: integer arithmetic is enough to give distinct results.
  function automatic logic [31:0] fpu_stub(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd4:    return a + b;
      5'd7:    return (b != 32'd0) ? a / b : 32'd0;
      5'd17:   return {31'd0, a == b};
      5'd20:   return 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.fpu_result    = fpu_stub(bus.fpu_op, bus.fpu_valA, bus.fpu_valB);
  always_comb bus_to.fpu_result = fpu_stub(bus_to.fpu_op, bus_to.fpu_valA, bus_to.fpu_valB);

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_rs3   = 32'hC0C0_0003;
    bus.req_rd    = rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic issue_to(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus_to.req_valid = 1'b1;
    bus_to.req_op    = op;
    bus_to.req_rs1   = a;
    bus_to.req_rs2   = b;
    bus_to.req_rs3   = 32'd0;
    bus_to.req_rd    = rd;
    @(negedge clk);
    bus_to.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if ({bus.req_ready, bus.active, bus.wb_valid, bus.wb_int} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 1000", {bus.req_ready, bus.active, bus.wb_valid, bus.wb_int}); end
    n_vec++; if (bus.fpu_op !== 5'd31) begin
      n_bad++; $display("FAIL reset_fpu_op: got %0d want 31", bus.fpu_op); end
    n_vec++; if ({bus.fpu_valA, bus.fpu_valB, bus.fpu_valC} !== 96'd0) begin
      n_bad++; $display("FAIL reset_fpu_val: got %h want 0", {bus.fpu_valA, bus.fpu_valB, bus.fpu_valC}); end
    n_vec++; if ({bus.wb_rd, bus.wb_data} !== 37'd0) begin
      n_bad++; $display("FAIL reset_wb: got rd=%0d data=%h want 0", bus.wb_rd, bus.wb_data); end
    n_vec++; if ({bus.fflags, bus.timeout_err} !== 6'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {bus.fflags, bus.timeout_err}); end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fadd();
    n_vec++; if (bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL fadd_ready_idle: got %b want 1", bus.req_ready); end
    issue(5'd4, 32'd5, 32'd3, 5'd7);
    n_vec++; if ({bus.active, bus.req_ready, bus.wb_valid, bus.fpu_op, bus.fpu_valA, bus.fpu_valB} !== {3'b100, 5'd4, 32'd5, 32'd3}) begin
      n_bad++; $display("FAIL fadd_exec: got act/rdy/wb=%b op=%0d a=%0d b=%0d want 100 4 5 3",
        {bus.active, bus.req_ready, bus.wb_valid}, bus.fpu_op, bus.fpu_valA, bus.fpu_valB); end
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_int} !== {1'b1, 32'd8, 5'd7, 1'b0}) begin
      n_bad++; $display("FAIL fadd_wb: got v=%b data=%0d rd=%0d int=%b want 1 8 7 0",
        bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_int); end
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.req_ready, bus.fpu_op, bus.fpu_valA} !== {2'b01, 5'd31, 32'd5}) begin
      n_bad++; $display("FAIL fadd_retire: got v=%b rdy=%b op=%0d a=%0d want 0 1 31 5",
        bus.wb_valid, bus.req_ready, bus.fpu_op, bus.fpu_valA); end
  endtask

  task automatic test_fdiv();
    bus.fpu_busy = 1'b1;
    pulses = 0;
    seen   = 32'd0;
    issue(5'd7, 32'd20, 32'd4, 5'd3);
    for (int j = 0; j < 16; j++) begin
      n_vec++; if (bus.wb_valid !== (j == 11)) begin
        n_bad++; $display("FAIL fdiv_wb_valid[%0d]: got %b want %b", j, bus.wb_valid, (j == 11)); end
      n_vec++; if (bus.active !== (j <= 11)) begin
        n_bad++; $display("FAIL fdiv_active[%0d]: got %b want %b", j, bus.active, (j <= 11)); end
      if (j <= 11) begin
        n_vec++; if ({bus.fpu_op, bus.fpu_valA, bus.fpu_valB} !== {5'd7, 32'd20, 32'd4}) begin
          n_bad++; $display("FAIL fdiv_stable[%0d]: got op=%0d a=%0d b=%0d want 7 20 4", j, bus.fpu_op, bus.fpu_valA, bus.fpu_valB); end
      end
      if (bus.wb_valid === 1'b1) begin
        pulses++;
        seen = bus.wb_data;
      end
      if (j == 10) bus.fpu_busy = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (pulses != 1 || seen !== 32'd5) begin
      n_bad++; $display("FAIL fdiv_result: got pulses=%0d data=%0d want 1 5", pulses, seen); end
    n_vec++; if (bus.fflags !== 5'b00000) begin
      n_bad++; $display("FAIL fdiv_flags: got %b want 00000", bus.fflags); end
  endtask

  task automatic test_timeout();
    issue_to(5'd4, 32'd6, 32'd1, 5'd1);
    @(negedge clk);
    n_vec++; if ({bus_to.wb_valid, bus_to.wb_data} !== {1'b1, 32'd7}) begin
      n_bad++; $display("FAIL tmo_pre_fadd: got v=%b data=%0d want 1 7", bus_to.wb_valid, bus_to.wb_data); end
    @(negedge clk);
    bus_to.fpu_busy = 1'b1;
    issue_to(5'd7, 32'd9, 32'd3, 5'd2);
    for (int j = 0; j < 12; j++) begin
      n_vec++; if (bus_to.wb_valid !== (j == 9)) begin
        n_bad++; $display("FAIL tmo_wb_valid[%0d]: got %b want %b", j, bus_to.wb_valid, (j == 9)); end
      if (j == 8) begin
        n_vec++; if (bus_to.timeout_err !== 1'b0) begin
          n_bad++; $display("FAIL tmo_early: got %b want 0", bus_to.timeout_err); end
      end
      if (j == 9) begin
        n_vec++; if ({bus_to.wb_data, bus_to.fflags, bus_to.timeout_err} !== {32'd0, 5'b10000, 1'b1}) begin
          n_bad++; $display("FAIL tmo_abandon: got data=%0d flags=%b err=%b want 0 10000 1",
            bus_to.wb_data, bus_to.fflags, bus_to.timeout_err); end
      end
      @(negedge clk);
    end
    bus_to.fpu_busy = 1'b0;
    issue_to(5'd4, 32'd2, 32'd2, 5'd1);
    @(negedge clk);
    n_vec++; if ({bus_to.wb_valid, bus_to.wb_data, bus_to.fflags, bus_to.timeout_err} !== {1'b1, 32'd4, 5'b10000, 1'b1}) begin
      n_bad++; $display("FAIL tmo_recover: got v=%b data=%0d flags=%b err=%b want 1 4 10000 1",
        bus_to.wb_valid, bus_to.wb_data, bus_to.fflags, bus_to.timeout_err); end
    @(negedge clk);
  endtask

  task automatic test_illegal_dz();
    issue(5'd25, 32'd1, 32'd1, 5'd9);
    n_vec++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.fflags, bus.fpu_op} !== {1'b1, 32'd0, 5'd9, 5'b10000, 5'd31}) begin
      n_bad++; $display("FAIL illegal_done: got v=%b data=%0d rd=%0d flags=%b op=%0d want 1 0 9 10000 31",
        bus.wb_valid, bus.wb_data, bus.wb_rd, bus.fflags, bus.fpu_op); end
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL illegal_retire: got %b want 01", {bus.wb_valid, bus.req_ready}); end
    issue(5'd7, 32'd8, 32'd0, 5'd4);
    repeat (2) @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.fflags} !== {1'b1, 5'b11000}) begin
      n_bad++; $display("FAIL dz_set: got v=%b flags=%b want 1 11000", bus.wb_valid, bus.fflags); end
    @(negedge clk);
    issue(5'd7, 32'd6, 32'd0, 5'd4);
    @(negedge clk);
    bus.fflags_clr = 1'b1;
    @(negedge clk);
    bus.fflags_clr = 1'b0;
    n_vec++; if ({bus.wb_valid, bus.fflags} !== {1'b1, 5'b01000}) begin
      n_bad++; $display("FAIL dz_set_vs_clr: got v=%b flags=%b want 1 01000", bus.wb_valid, bus.fflags); end
    @(negedge clk);
    bus.fflags_clr = 1'b1;
    @(negedge clk);
    bus.fflags_clr = 1'b0;
    n_vec++; if (bus.fflags !== 5'b00000) begin
      n_bad++; $display("FAIL flags_clr: got %b want 00000", bus.fflags); end
  endtask

  task automatic test_overflow();
    bus.fpu_overflow = 1'b1;
    issue(5'd4, 32'd1, 32'd1, 5'd6);
    @(negedge clk);
    n_vec++; if (bus.fflags !== 5'b00000) begin
      n_bad++; $display("FAIL of_non_cvt: got %b want 00000", bus.fflags); end
    @(negedge clk);
    issue(5'd21, 32'd1, 32'd1, 5'd6);
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.wb_int, bus.fflags} !== {2'b10, 5'b00100}) begin
      n_bad++; $display("FAIL of_set: got v=%b int=%b flags=%b want 1 0 00100", bus.wb_valid, bus.wb_int, bus.fflags); end
    bus.fpu_overflow = 1'b0;
    bus.fflags_clr   = 1'b1;
    @(negedge clk);
    bus.fflags_clr   = 1'b0;
  endtask

  task automatic test_int_dest();
    issue(5'd17, 32'h3F80_0000, 32'h3F80_0000, 5'd11);
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data} !== {2'b11, 5'd11, 32'd1}) begin
      n_bad++; $display("FAIL feq_int: got v=%b int=%b rd=%0d data=%0d want 1 1 11 1",
        bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data); end
    @(negedge clk);
    issue(5'd20, 32'd0, 32'd0, 5'd12);
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.wb_int, bus.wb_data} !== {2'b11, 32'd2}) begin
      n_bad++; $display("FAIL op20_int: got v=%b int=%b data=%0d want 1 1 2", bus.wb_valid, bus.wb_int, bus.wb_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1;
    bus.req_op    = 5'd4;
    bus.req_rs1   = 32'd1;
    bus.req_rs2   = 32'd2;
    bus.req_rd    = 5'd1;
    @(negedge clk);
    bus.req_rs1 = 32'd10;
    bus.req_rs2 = 32'd20;
    bus.req_rd  = 5'd2;
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.req_ready, bus.wb_data} !== {2'b10, 32'd3}) begin
      n_bad++; $display("FAIL b2b_first: got v=%b rdy=%b data=%0d want 1 0 3", bus.wb_valid, bus.req_ready, bus.wb_data); end
    @(negedge clk);
    n_vec++; if ({bus.req_ready, bus.active} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_bubble: got rdy/act=%b want 10", {bus.req_ready, bus.active}); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_vec++; if ({bus.active, bus.fpu_valA} !== {1'b1, 32'd10}) begin
      n_bad++; $display("FAIL b2b_second_accept: got act=%b a=%0d want 1 10", bus.active, bus.fpu_valA); end
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd2, 32'd30}) begin
      n_bad++; $display("FAIL b2b_second: got v=%b rd=%0d data=%0d want 1 2 30", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bus.fpu_busy = 1'b1;
    issue(5'd7, 32'd20, 32'd4, 5'd5);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    n_vec++; if ({bus.req_ready, bus.active, bus.wb_valid, bus.fpu_op} !== {3'b100, 5'd31}) begin
      n_bad++; $display("FAIL rst_mid_ctl: got rdy/act/v=%b op=%0d want 100 31",
        {bus.req_ready, bus.active, bus.wb_valid}, bus.fpu_op); end
    n_vec++; if ({bus.fpu_valA, bus.fpu_valB, bus.wb_rd, bus.wb_data} !== 101'd0) begin
      n_bad++; $display("FAIL rst_mid_regs: got a=%0d b=%0d rd=%0d data=%0d want 0",
        bus.fpu_valA, bus.fpu_valB, bus.wb_rd, bus.wb_data); end
    n_vec++; if ({bus_to.fflags, bus_to.timeout_err} !== 6'd0) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b want 000000", {bus_to.fflags, bus_to.timeout_err}); end
    @(negedge clk);
    nrst = 1'b1;
    bus.fpu_busy = 1'b0;
    pulses = 0;
    for (int j = 0; j < 4; j++) begin
      if (bus.wb_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    n_vec++; if (pulses != 0) begin
      n_bad++; $display("FAIL rst_mid_no_wb: got %0d pulses want 0", pulses); end
    issue(5'd4, 32'd5, 32'd3, 5'd7);
    @(negedge clk);
    n_vec++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd} !== {1'b1, 32'd8, 5'd7}) begin
      n_bad++; $display("FAIL rst_mid_recover: got v=%b data=%0d rd=%0d want 1 8 7", bus.wb_valid, bus.wb_data, bus.wb_rd); end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    nrst  = 1'b0;
    bus.req_valid    = 1'b0;  bus_to.req_valid    = 1'b0;
    bus.req_op       = 5'd0;  bus_to.req_op       = 5'd0;
    bus.req_rs1      = 32'd0; bus_to.req_rs1      = 32'd0;
    bus.req_rs2      = 32'd0; bus_to.req_rs2      = 32'd0;
    bus.req_rs3      = 32'd0; bus_to.req_rs3      = 32'd0;
    bus.req_rd       = 5'd0;  bus_to.req_rd       = 5'd0;
    bus.fpu_busy     = 1'b0;  bus_to.fpu_busy     = 1'b0;
    bus.fpu_overflow = 1'b0;  bus_to.fpu_overflow = 1'b0;
    bus.fflags_clr   = 1'b0;  bus_to.fflags_clr   = 1'b0;

    test_reset();
    test_fadd();
    test_fdiv();
    test_timeout();
    test_illegal_dz();
    test_overflow();
    test_int_dest();
    test_back_to_back();
    test_reset_mid_op();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
